// File: rtl/poly_ram_reader_pkg.sv
// poly_ram_reader_pkg
//   Shared definitions for the polynomial RAM read controller:
//   - COMMON_BRAM_DELAY : BRAM read latency (addrb -> doutb) in cycles,
//                         taken from the `COMMON_BRAM_DELAY macro (default 2)
//   - state_t           : controller FSM states
//   - bitrev()          : reverses the low 'width' bits of a value
package poly_ram_reader_pkg;

`ifndef COMMON_BRAM_DELAY
`define COMMON_BRAM_DELAY 2
`endif

  localparam int COMMON_BRAM_DELAY = `COMMON_BRAM_DELAY;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Bit i of the result is bit (width-1-i) of value; bits at or above width are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) r[i] = value[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/poly_ram_reader_if.sv
// poly_ram_reader_if
//   Valid/ready beat stream leaving the reader.
//   out_valid : beat available
//   out_ready : consumer accepts
//   out_data  : one beat (all banks at one address)
//   out_last  : final beat of the transfer
//   Modports: master = reader side, slave = consumer side.
interface poly_ram_reader_if #(
  parameter int DATA_WIDTH = 312
) ();
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/poly_rd_fifo.sv
// poly_rd_fifo
//   Synchronous FIFO that buffers RAM read data for the output stream.
//   clk, rst_n : clock, async active-low reset (clears pointers and count)
//   wr_en/wr_data : push (accepted when not full, or when popping the same cycle)
//   rd_en/rd_data : pop (ignored when empty); rd_data shows the head entry
//   count, empty  : occupancy
module poly_rd_fifo #(
  parameter int WIDTH = 312,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, do_wr, do_rd;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: storage is not reset; only pointers/count are, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= next_ptr(wr_ptr);
      if (do_rd) rd_ptr <= next_ptr(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/poly_ram_reader.sv
// poly_ram_reader
//   Streams a polynomial out of NUM_BASE_BANK RAM banks as valid/ready beats,
//   one beat = all banks at one address. Reads are issued only while the output
//   FIFO can absorb every outstanding read, so backpressure never drops data.
//   Build option: define POLY_RAM_READER_BITREV_EN to read beat i from
//   base_addr + bitrev(i) instead of base_addr + i.
// Ports
//   clk, rst_n          clock, async active-low reset
//   start, base_addr,   launch a transfer of len beats from base_addr
//   len                 (start is only sampled while idle)
//   busy, done          transfer in progress / 1-cycle completion pulse
//   ram_addrb           read address, replicated to every bank
//   ram_doutb           read data from the banks, COMMON_BRAM_DELAY after addrb
//   stream              output beat stream (master side)
module poly_ram_reader
  import poly_ram_reader_pkg::*;
#(
  parameter int COE_WIDTH     = 39,
  parameter int ADDR_WIDTH    = 9,
  parameter int NUM_BASE_BANK = 8,
  parameter int FIFO_DEPTH    = COMMON_BRAM_DELAY + 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [ADDR_WIDTH-1:0]             base_addr,
  input  logic [ADDR_WIDTH:0]               len,
  output logic                              busy,
  output logic                              done,
  output logic [ADDR_WIDTH*NUM_BASE_BANK-1:0] ram_addrb,
  input  logic [COE_WIDTH*NUM_BASE_BANK-1:0]  ram_doutb,
  poly_ram_reader_if.master                 stream
);
  localparam int DATA_W = COE_WIDTH * NUM_BASE_BANK;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  // One stage for the cycle addrb is on the bus, then COMMON_BRAM_DELAY stages of RAM latency.
  localparam int PIPE_N = COMMON_BRAM_DELAY + 1;
  localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH + 1)'(1);

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] base_q, addr_q, issue_off, issue_addr;
  logic [ADDR_WIDTH:0]   len_q, issued, accepted, issue_idx;
  logic [PIPE_N-1:0]     pipe;
  logic [CNT_W-1:0]      fifo_count, inflight;
  logic [CNT_W:0]        used;
  logic                  fifo_empty, credit_ok, issue, pop, last_pop, done_next;

  // ---------------- issue address ----------------
  assign issue_idx = (state == ST_IDLE) ? '0 : issued;
`ifdef POLY_RAM_READER_BITREV_EN
  assign issue_off = ADDR_WIDTH'(bitrev(32'(issue_idx[ADDR_WIDTH-1:0]), ADDR_WIDTH));
`else
  assign issue_off = issue_idx[ADDR_WIDTH-1:0];
`endif
  // Sum truncates to ADDR_WIDTH bits, so addresses wrap past the top of the bank.
  assign issue_addr = ((state == ST_IDLE) ? base_addr : base_q) + issue_off;

  // ---------------- credit ----------------
  always_comb begin
    inflight = '0;
    for (int i = 0; i < PIPE_N; i++) inflight = inflight + CNT_W'(pipe[i]);
  end

  // A beat leaving the FIFO this cycle frees its slot, which keeps 1 beat/cycle under full flow.
  assign used      = (CNT_W + 1)'(inflight) + (CNT_W + 1)'(fifo_count) - (CNT_W + 1)'(pop);
  assign credit_ok = (used < (CNT_W + 1)'(FIFO_DEPTH));

  // ---------------- output side ----------------
  assign stream.out_valid = !fifo_empty;
  assign stream.out_last  = stream.out_valid && (accepted == len_q - ONE);
  assign pop              = stream.out_valid && stream.out_ready;
  assign last_pop         = pop && stream.out_last;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    done_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_next = 1'b1;
          end else begin
            // The pipe is empty when idle, so the first read never needs a credit check.
            issue      = 1'b1;
            state_next = (len == ONE) ? ST_DRAIN : ST_READ;
          end
        end
      end
      ST_READ: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (issued == len_q - ONE) state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (last_pop) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q   <= '0;
      len_q    <= '0;
      issued   <= '0;
      accepted <= '0;
      addr_q   <= '0;
      pipe     <= '0;
      done     <= 1'b0;
    end else begin
      done <= done_next;
      pipe <= {pipe[PIPE_N-2:0], issue};
      if (state == ST_IDLE && start) begin
        base_q   <= base_addr;
        len_q    <= len;
        accepted <= '0;
      end
      if (issue) begin
        addr_q <= issue_addr;
        issued <= issue_idx + ONE;
      end
      if (pop) accepted <= accepted + ONE;
    end
  end

  assign busy      = (state != ST_IDLE);
  assign ram_addrb = {NUM_BASE_BANK{addr_q}};

  poly_rd_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (pipe[PIPE_N-1]),
    .wr_data (ram_doutb),
    .rd_en   (pop),
    .rd_data (stream.out_data),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );
endmodule

// File: tb/tb_poly_ram_reader.sv
// tb_poly_ram_reader
//   Directed bench for poly_ram_reader. A RAM model returns {bank, addr} per bank
//   after COMMON_BRAM_DELAY cycles. A queue of expected beat addresses, derived from
//   base/len alone, is checked against the stream on every falling edge.
module tb_poly_ram_reader;
  import poly_ram_reader_pkg::*;

  localparam int AW = 9;
  localparam int NB = 8;
  localparam int CW = 39;
  localparam int DW = CW * NB;

  typedef struct {
    logic [AW-1:0] addr;
    logic          last;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [AW-1:0]    base_addr = '0;
  logic [AW:0]      len = '0;
  logic             busy, done;
  logic [AW*NB-1:0] ram_addrb;
  logic [DW-1:0]    ram_doutb;

  poly_ram_reader_if #(.DATA_WIDTH(DW)) stream_if ();

  poly_ram_reader #(
    .COE_WIDTH(CW), .ADDR_WIDTH(AW), .NUM_BASE_BANK(NB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .ram_addrb(ram_addrb), .ram_doutb(ram_doutb),
    .stream(stream_if.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RAM model ----------------
  logic [AW*NB-1:0] rd_pipe [COMMON_BRAM_DELAY];
  always @(posedge clk) begin
    rd_pipe[0] <= ram_addrb;
    for (int i = 1; i < COMMON_BRAM_DELAY; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  always_comb begin
    ram_doutb = '0;
    for (int k = 0; k < NB; k++)
      ram_doutb[k*CW +: CW] = CW'(k * 512 + int'(rd_pipe[COMMON_BRAM_DELAY-1][k*AW +: AW]));
  end

  // ---------------- behavioural model ----------------
  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    logic [DW-1:0] d;
    d = '0;
    for (int k = 0; k < NB; k++) d[k*CW +: CW] = CW'(k * 512 + int'(a));
    return d;
  endfunction

  function automatic logic [AW-1:0] beat_offset(input int i);
    logic [AW-1:0] r;
    r = '0;
`ifdef POLY_RAM_READER_BITREV_EN
    for (int b = 0; b < AW; b++) r[b] = i[AW-1-b];
`else
    r = AW'(i);
`endif
    return r;
  endfunction

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  beat_t         exp_q[$];
  logic [AW-1:0] acc_log[$];
  bit            mon_en = 1'b0;
  bit            done_due = 1'b0;
  int            done_cnt = 0;
  int            accept_cnt = 0;
  int            done_cyc = -1;
  int            first_valid_cyc = -1;
  int            last_acc_cyc = -1;
  logic [DW-1:0] first_data;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  int            ready_mode = 0;

  // ---------------- consumer ready ----------------
  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) stream_if.out_ready = 1'b1;
    else                 stream_if.out_ready = ($urandom_range(0, 9) < 3);
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    beat_t front;
    if (rst_n && mon_en) begin
      if (done_due) begin
        check("done_pulse", DW'(done), DW'(1));
        check("busy_at_done", DW'(busy), DW'(0));
        done_due = 1'b0;
        done_cnt++;
        done_cyc = cyc;
      end else begin
        check("done_quiet", DW'(done), DW'(0));
      end
      if (stall_prev) begin
        check("hold_valid", DW'(stream_if.out_valid), DW'(1));
        check("hold_data", stream_if.out_data, prev_data);
        check("hold_last", DW'(stream_if.out_last), DW'(prev_last));
      end
      if (stream_if.out_valid) begin
        check("busy_while_valid", DW'(busy), DW'(1));
        if (exp_q.size() == 0) begin
          check("spurious_valid", DW'(stream_if.out_valid), DW'(0));
        end else begin
          front = exp_q[0];
          check("beat_data", stream_if.out_data, exp_data(front.addr));
          check("beat_last", DW'(stream_if.out_last), DW'(front.last));
          if (first_valid_cyc < 0) begin
            first_valid_cyc = cyc;
            first_data      = stream_if.out_data;
          end
          if (stream_if.out_ready) begin
            void'(exp_q.pop_front());
            acc_log.push_back(stream_if.out_data[AW-1:0]);
            accept_cnt++;
            if (front.last) begin
              done_due     = 1'b1;
              last_acc_cyc = cyc;
            end
          end
        end
      end
      stall_prev = stream_if.out_valid && !stream_if.out_ready;
      prev_data  = stream_if.out_data;
      prev_last  = stream_if.out_last;
    end
  end

  // ---------------- stimulus ----------------
  int t0;

  task automatic launch(input logic [AW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.addr = base + beat_offset(i);
      b.last = (i == n - 1);
      exp_q.push_back(b);
    end
    first_valid_cyc = -1;
    @(negedge clk);
    start     = 1'b1;
    base_addr = base;
    len       = (AW + 1)'(n);
    t0        = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (n == 0) done_due = 1'b1;
  endtask

  task automatic run(input logic [AW-1:0] base, input int n, input int budget);
    int d0;
    int k;
    d0 = done_cnt;
    launch(base, n);
    k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    @(posedge clk);
    check("transfer_completed", DW'(done_cnt - d0), DW'(1));
    check("queue_drained", DW'(exp_q.size()), DW'(0));
  endtask

  int i0;
  logic [AW*NB-1:0] addr_before;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    stream_if.out_ready = 1'b1;
    #1;
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_done", DW'(done), DW'(0));
    check("rst_valid", DW'(stream_if.out_valid), DW'(0));
    check("rst_last", DW'(stream_if.out_last), DW'(0));
    check("rst_addrb", DW'(ram_addrb), DW'(0));
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    mon_en = 1'b1;

    // 1: base 0, len 16, always ready
    ready_mode = 0;
    i0 = acc_log.size();
    run(9'd0, 16, 200);
    check("t1_first_valid_latency", DW'(first_valid_cyc - t0), DW'(COMMON_BRAM_DELAY + 2));
    check("t1_last_accept_cycle", DW'(last_acc_cyc - t0), DW'(COMMON_BRAM_DELAY + 17));
    check("t1_done_cycle", DW'(done_cyc - t0), DW'(COMMON_BRAM_DELAY + 18));
    check("t1_beats", DW'(acc_log.size() - i0), DW'(16));
    check("t1_busy_after", DW'(busy), DW'(0));

    // 2: wrap past the top of the bank
    i0 = acc_log.size();
    run(9'd510, 4, 200);
`ifndef POLY_RAM_READER_BITREV_EN
    check("t2_addr0", DW'(acc_log[i0]), DW'(510));
    check("t2_addr1", DW'(acc_log[i0+1]), DW'(511));
    check("t2_addr2", DW'(acc_log[i0+2]), DW'(0));
    check("t2_addr3", DW'(acc_log[i0+3]), DW'(1));
    check("t2_bank7_first", DW'(first_data[7*CW +: CW]), DW'(4094));
`endif

    // 3: 30% ready backpressure
    ready_mode = 1;
    i0 = acc_log.size();
    run(9'd300, 32, 3000);
    check("t3_beats", DW'(acc_log.size() - i0), DW'(32));
    ready_mode = 0;

    // 4: zero-length transfer
    repeat (2) @(posedge clk);
    addr_before = ram_addrb;
    run(9'd77, 0, 50);
    check("t4_done_cycle", DW'(done_cyc - t0), DW'(1));
    repeat (4) @(posedge clk);
    check("t4_addrb_unchanged", DW'(ram_addrb), DW'(addr_before));
    check("t4_busy", DW'(busy), DW'(0));

    // 5: reset in the middle of a len-64 transfer
    begin
      int a0;
      int k;
      a0 = accept_cnt;
      launch(9'd200, 64);
      k = 0;
      while (accept_cnt < a0 + 5 && k < 300) begin
        @(posedge clk);
        k++;
      end
      check("t5_reached_beat5", DW'(accept_cnt >= a0 + 5), DW'(1));
      #2 rst_n = 1'b0;
      mon_en = 1'b0;
      #1;
      check("t5_rst_busy", DW'(busy), DW'(0));
      check("t5_rst_valid", DW'(stream_if.out_valid), DW'(0));
      check("t5_rst_done", DW'(done), DW'(0));
      check("t5_rst_addrb", DW'(ram_addrb), DW'(0));
      exp_q.delete();
      done_due   = 1'b0;
      stall_prev = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      mon_en = 1'b1;
    end
    i0 = acc_log.size();
    run(9'd100, 2, 200);
    check("t5_beats_after_reset", DW'(acc_log.size() - i0), DW'(2));
`ifndef POLY_RAM_READER_BITREV_EN
    check("t5_addr0", DW'(acc_log[i0]), DW'(100));
    check("t5_addr1", DW'(acc_log[i0+1]), DW'(101));
`endif

`ifdef POLY_RAM_READER_BITREV_EN
    // 6: full-depth bit-reversed read
    i0 = acc_log.size();
    run(9'd0, 512, 3000);
    check("t6_beats", DW'(acc_log.size() - i0), DW'(512));
    check("t6_beat1", DW'(acc_log[i0+1]), DW'(256));
    check("t6_beat2", DW'(acc_log[i0+2]), DW'(128));
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
